vscale_imm_arb: RTL and testbench

//  Two-requester arbiter for the shared immediate generator. Requester 0 is
//  the decode stage; requester 1 is the fetch-side branch target precompute.

---
 rtl/vscale_imm_arb_if.sv | 64 ++++++
 rtl/vscale_imm_arb.sv | 122 ++++++++++++
 tb/tb_vscale_imm_arb.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/vscale_imm_arb_if.sv
// Request/response/generator bundle for vscale_imm_arb; the arbiter takes the slave view.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef IMM_TYPE_WIDTH
`define IMM_TYPE_WIDTH 2
`endif
`ifndef IMM_I
`define IMM_I 2'd0
`define IMM_S 2'd1
`define IMM_U 2'd2
`define IMM_J 2'd3
`endif

interface vscale_imm_arb_if #(
   parameter int TAG_W = 4
) ();
   logic                       req0_valid;
   logic                       req0_ready;
   logic [`XPR_LEN-1:0]        req0_inst;
   logic [`IMM_TYPE_WIDTH-1:0] req0_imm_type;
   logic [TAG_W-1:0]           req0_tag;
   logic                       req1_valid;
   logic                       req1_ready;
   logic [`XPR_LEN-1:0]        req1_inst;
   logic [`IMM_TYPE_WIDTH-1:0] req1_imm_type;
   logic [TAG_W-1:0]           req1_tag;
   logic [`XPR_LEN-1:0]        gen_inst;
   logic [`IMM_TYPE_WIDTH-1:0] gen_imm_type;
   logic [`XPR_LEN-1:0]        gen_imm;
   logic                       rsp0_valid;
   logic                       rsp0_ready;
   logic [`XPR_LEN-1:0]        rsp0_imm;
   logic [TAG_W-1:0]           rsp0_tag;
   logic                       rsp1_valid;
   logic                       rsp1_ready;
   logic [`XPR_LEN-1:0]        rsp1_imm;
   logic [TAG_W-1:0]           rsp1_tag;
   logic                       kill;

   modport slave (
      input  req0_valid, req0_inst, req0_imm_type, req0_tag,
      input  req1_valid, req1_inst, req1_imm_type, req1_tag,
      output req0_ready, req1_ready,
      output gen_inst, gen_imm_type,
      input  gen_imm,
      output rsp0_valid, rsp0_imm, rsp0_tag,
      output rsp1_valid, rsp1_imm, rsp1_tag,
      input  rsp0_ready, rsp1_ready,
      input  kill
   );

   modport master (
      output req0_valid, req0_inst, req0_imm_type, req0_tag,
      output req1_valid, req1_inst, req1_imm_type, req1_tag,
      input  req0_ready, req1_ready,
      input  gen_inst, gen_imm_type,
      output gen_imm,
      input  rsp0_valid, rsp0_imm, rsp0_tag,
      input  rsp1_valid, rsp1_imm, rsp1_tag,
      output rsp0_ready, rsp1_ready,
      output kill
   );
endinterface

// File: rtl/vscale_imm_arb.sv
// Round-robin arbiter sharing one immediate generator between decode and branch precompute.
// Optional statistics counters are enabled by defining VSCALE_IMM_ARB_STATS_EN.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef IMM_TYPE_WIDTH
`define IMM_TYPE_WIDTH 2
`endif
`ifndef IMM_I
`define IMM_I 2'd0
`define IMM_S 2'd1
`define IMM_U 2'd2
`define IMM_J 2'd3
`endif

module vscale_imm_arb #(
   parameter int TAG_W = 4
) (
   input  logic                clk,
   input  logic                reset,
`ifdef VSCALE_IMM_ARB_STATS_EN
   output logic [15:0]         stat_conflicts,
   output logic [15:0]         stat_stalls,
`endif
   vscale_imm_arb_if.slave     bus
);
   logic                lastg;
   logic                elig0, elig1;
   logic                grant0, grant1;
   logic                rsp0_valid_q, rsp1_valid_q;
   logic [`XPR_LEN-1:0] rsp0_imm_q, rsp1_imm_q;
   logic [TAG_W-1:0]    rsp0_tag_q, rsp1_tag_q;

   // A slot can take a new result if empty or being popped this same cycle.
   always_comb begin
      elig0  = bus.req0_valid & (!rsp0_valid_q | bus.rsp0_ready) & !bus.kill & !reset;
      elig1  = bus.req1_valid & (!rsp1_valid_q | bus.rsp1_ready) & !bus.kill & !reset;
      grant0 = elig0 & (!elig1 | lastg);
      grant1 = elig1 & (!elig0 | !lastg);
   end

   always_comb begin
      bus.gen_inst     = '0;
      bus.gen_imm_type = `IMM_I;
      if (grant0) begin
         bus.gen_inst     = bus.req0_inst;
         bus.gen_imm_type = bus.req0_imm_type;
      end else if (grant1) begin
         bus.gen_inst     = bus.req1_inst;
         bus.gen_imm_type = bus.req1_imm_type;
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp0_imm   = rsp0_imm_q;
   assign bus.rsp0_tag   = rsp0_tag_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.rsp1_imm   = rsp1_imm_q;
   assign bus.rsp1_tag   = rsp1_tag_q;

   // lastg resets to 1 so requester 0 wins the first conflict.
   always_ff @(posedge clk) begin
      if (reset) begin
         lastg <= 1'b1;
      end else if (grant0 | grant1) begin
         lastg <= grant1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp0_valid_q <= 1'b0;
         rsp0_imm_q   <= '0;
         rsp0_tag_q   <= '0;
      end else if (bus.kill) begin
         rsp0_valid_q <= 1'b0;
      end else if (grant0) begin
         rsp0_valid_q <= 1'b1;
         rsp0_imm_q   <= bus.gen_imm;
         rsp0_tag_q   <= bus.req0_tag;
      end else if (bus.rsp0_ready) begin
         rsp0_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp1_valid_q <= 1'b0;
         rsp1_imm_q   <= '0;
         rsp1_tag_q   <= '0;
      end else if (bus.kill) begin
         rsp1_valid_q <= 1'b0;
      end else if (grant1) begin
         rsp1_valid_q <= 1'b1;
         rsp1_imm_q   <= bus.gen_imm;
         rsp1_tag_q   <= bus.req1_tag;
      end else if (bus.rsp1_ready) begin
         rsp1_valid_q <= 1'b0;
      end
   end

`ifdef VSCALE_IMM_ARB_STATS_EN
   logic conflict, stall;

   always_comb begin
      conflict = bus.req0_valid & bus.req1_valid & !bus.kill;
      stall    = (bus.req0_valid & !grant0) | (bus.req1_valid & !grant1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_conflicts <= '0;
         stat_stalls    <= '0;
      end else begin
         if (conflict && stat_conflicts != 16'hFFFF) stat_conflicts <= stat_conflicts + 16'd1;
         if (stall && stat_stalls != 16'hFFFF) stat_stalls <= stat_stalls + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_vscale_imm_arb.sv
// Testbench for vscale_imm_arb: directed vector table, then randomized traffic against a model.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef IMM_TYPE_WIDTH
`define IMM_TYPE_WIDTH 2
`endif
`ifndef IMM_I
`define IMM_I 2'd0
`define IMM_S 2'd1
`define IMM_U 2'd2
`define IMM_J 2'd3
`endif

module tb_vscale_imm_arb;
   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   vscale_imm_arb_if #(.TAG_W(4)) bus ();

`ifdef VSCALE_IMM_ARB_STATS_EN
   logic [15:0] stat_conflicts, stat_stalls;
   int          m_conf, m_stall;
   vscale_imm_arb #(.TAG_W(4)) dut (.clk(clk), .reset(reset),
      .stat_conflicts(stat_conflicts), .stat_stalls(stat_stalls), .bus(bus));
`else
   vscale_imm_arb #(.TAG_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

   function automatic logic [31:0] imm_fn(input logic [31:0] i, input logic [1:0] t);
      case (t)
         `IMM_S:  return {{21{i[31]}}, i[30:25], i[11:7]};
         `IMM_U:  return {i[31:12], 12'b0};
         `IMM_J:  return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
         default: return {{21{i[31]}}, i[30:20]};
      endcase
   endfunction

   // Stand-in for the external immediate generator.
   assign bus.gen_imm = imm_fn(bus.gen_inst, bus.gen_imm_type);

   typedef struct {
      logic v0; logic [31:0] i0; logic [1:0] t0; logic [3:0] g0;
      logic v1; logic [31:0] i1; logic [1:0] t1; logic [3:0] g1;
      logic r0; logic r1; logic k; logic rs;
      logic e_rdy0; logic e_rdy1;
      logic e_v0; logic [31:0] e_imm0; logic [3:0] e_tag0;
      logic e_v1; logic [31:0] e_imm1; logic [3:0] e_tag1;
   } vec_t;

   logic        m_v[2];
   logic [31:0] m_imm[2];
   logic [3:0]  m_tag[2];
   int          m_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input vec_t v, input bit use_tab);
      logic el[2];
      logic vv[2], rr[2];
      int   w;
      logic [31:0] e_gi;
      logic [1:0]  e_gt;
      @(negedge clk);
      reset = v.rs;
      bus.req0_valid = v.v0; bus.req0_inst = v.i0; bus.req0_imm_type = v.t0; bus.req0_tag = v.g0;
      bus.req1_valid = v.v1; bus.req1_inst = v.i1; bus.req1_imm_type = v.t1; bus.req1_tag = v.g1;
      bus.rsp0_ready = v.r0; bus.rsp1_ready = v.r1; bus.kill = v.k;
      #1;
      vv[0] = v.v0; vv[1] = v.v1; rr[0] = v.r0; rr[1] = v.r1;
      for (int n = 0; n < 2; n++) el[n] = vv[n] && (!m_v[n] || rr[n]) && !v.k && !v.rs;
      if (el[0] && el[1]) w = 1 - m_last;
      else if (el[0]) w = 0;
      else if (el[1]) w = 1;
      else w = -1;
      e_gi = (w == 0) ? v.i0 : (w == 1) ? v.i1 : 32'd0;
      e_gt = (w == 0) ? v.t0 : (w == 1) ? v.t1 : `IMM_I;
      chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, w == 0});
      chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, w == 1});
      chk("gen_inst", bus.gen_inst, e_gi);
      chk("gen_imm_type", {30'd0, bus.gen_imm_type}, {30'd0, e_gt});
      if (use_tab) begin
         chk("tab_req0_ready", {31'd0, bus.req0_ready}, {31'd0, v.e_rdy0});
         chk("tab_req1_ready", {31'd0, bus.req1_ready}, {31'd0, v.e_rdy1});
      end
`ifdef VSCALE_IMM_ARB_STATS_EN
      if (v.rs) begin
         m_conf = 0; m_stall = 0;
      end else begin
         if (v.v0 && v.v1 && !v.k && m_conf < 65535) m_conf++;
         if (((v.v0 && w != 0) || (v.v1 && w != 1)) && m_stall < 65535) m_stall++;
      end
`endif
      if (v.rs) begin
         for (int n = 0; n < 2; n++) begin m_v[n] = 0; m_imm[n] = 0; m_tag[n] = 0; end
         m_last = 1;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (v.k) m_v[n] = 0;
            else if (w == n) begin
               m_v[n]   = 1;
               m_imm[n] = (n == 0) ? imm_fn(v.i0, v.t0) : imm_fn(v.i1, v.t1);
               m_tag[n] = (n == 0) ? v.g0 : v.g1;
            end else if (rr[n]) m_v[n] = 0;
         end
         if (w >= 0) m_last = w;
      end
      @(posedge clk);
      #1;
      chk("rsp0_valid", {31'd0, bus.rsp0_valid}, {31'd0, m_v[0]});
      chk("rsp0_imm", bus.rsp0_imm, m_imm[0]);
      chk("rsp0_tag", {28'd0, bus.rsp0_tag}, {28'd0, m_tag[0]});
      chk("rsp1_valid", {31'd0, bus.rsp1_valid}, {31'd0, m_v[1]});
      chk("rsp1_imm", bus.rsp1_imm, m_imm[1]);
      chk("rsp1_tag", {28'd0, bus.rsp1_tag}, {28'd0, m_tag[1]});
`ifdef VSCALE_IMM_ARB_STATS_EN
      chk("stat_conflicts", {16'd0, stat_conflicts}, m_conf[31:0]);
      chk("stat_stalls", {16'd0, stat_stalls}, m_stall[31:0]);
`endif
      if (use_tab) begin
         chk("tab_rsp0_valid", {31'd0, bus.rsp0_valid}, {31'd0, v.e_v0});
         chk("tab_rsp0_imm", bus.rsp0_imm, v.e_imm0);
         chk("tab_rsp0_tag", {28'd0, bus.rsp0_tag}, {28'd0, v.e_tag0});
         chk("tab_rsp1_valid", {31'd0, bus.rsp1_valid}, {31'd0, v.e_v1});
         chk("tab_rsp1_imm", bus.rsp1_imm, v.e_imm1);
         chk("tab_rsp1_tag", {28'd0, bus.rsp1_tag}, {28'd0, v.e_tag1});
      end
   endtask

   localparam logic [31:0] IA = 32'h00500093;  // addi, imm 5
   localparam logic [31:0] IB = 32'h00A00113;  // addi, imm 10
   localparam logic [31:0] IU = 32'h123450B7;

   vec_t vt[20];
   vec_t rv;

   initial begin
      reset = 1'b1;
      bus.req0_valid = 0; bus.req0_inst = 0; bus.req0_imm_type = 0; bus.req0_tag = 0;
      bus.req1_valid = 0; bus.req1_inst = 0; bus.req1_imm_type = 0; bus.req1_tag = 0;
      bus.rsp0_ready = 0; bus.rsp1_ready = 0; bus.kill = 0;
      for (int n = 0; n < 2; n++) begin m_v[n] = 0; m_imm[n] = 0; m_tag[n] = 0; end
      m_last = 1;
`ifdef VSCALE_IMM_ARB_STATS_EN
      m_conf = 0; m_stall = 0;
`endif
      //        v0 i0            t0     g0  v1 i1            t1     g1  r0 r1 k rs  rdy0 rdy1 ev0 eimm0         etag0 ev1 eimm1         etag1
      vt[0]  = '{1, 32'hFFF00093, `IMM_I, 3, 0, 0,            `IMM_I, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0,        0,  0, 32'h0,        0};
      vt[1]  = '{1, 32'hFFF00093, `IMM_I, 3, 0, 0,            `IMM_I, 0, 1, 1, 0, 0, 1, 0, 1, 32'hFFFFFFFF, 3,  0, 32'h0,        0};
      vt[2]  = '{0, 0,            `IMM_I, 0, 0, 0,            `IMM_I, 0, 1, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 3,  0, 32'h0,        0};
      vt[3]  = '{0, 0,            `IMM_I, 0, 1, IU,           `IMM_U, 1, 1, 1, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 3,  1, 32'h12345000, 1};
      vt[4]  = '{0, 0,            `IMM_I, 0, 1, 32'h0020A423, `IMM_S, 2, 1, 1, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 3,  1, 32'h00000008, 2};
      vt[5]  = '{0, 0,            `IMM_I, 0, 1, 32'hFFDFF06F, `IMM_J, 4, 1, 1, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 3,  1, 32'hFFFFFFFC, 4};
      vt[6]  = '{1, IA,           `IMM_I, 5, 1, IB,           `IMM_I, 6, 1, 1, 0, 1, 0, 0, 0, 32'h0,        0,  0, 32'h0,        0};
      vt[7]  = '{1, IA,           `IMM_I, 5, 1, IB,           `IMM_I, 6, 1, 1, 0, 0, 1, 0, 1, 32'd5,        5,  0, 32'h0,        0};
      vt[8]  = '{1, IA,           `IMM_I, 5, 1, IB,           `IMM_I, 6, 1, 1, 0, 0, 0, 1, 0, 32'd5,        5,  1, 32'd10,       6};
      vt[9]  = '{1, IA,           `IMM_I, 7, 1, IB,           `IMM_I, 6, 1, 1, 0, 0, 1, 0, 1, 32'd5,        7,  0, 32'd10,       6};
      vt[10] = '{1, IA,           `IMM_I, 7, 1, IB,           `IMM_I, 8, 1, 1, 0, 0, 0, 1, 0, 32'd5,        7,  1, 32'd10,       8};
      vt[11] = '{1, IA,           `IMM_I, 9, 1, IB,           `IMM_I,10, 0, 1, 0, 0, 1, 0, 1, 32'd5,        9,  0, 32'd10,       8};
      vt[12] = '{1, IA,           `IMM_I,11, 1, IB,           `IMM_I,12, 0, 1, 0, 0, 0, 1, 1, 32'd5,        9,  1, 32'd10,      12};
      vt[13] = '{1, IA,           `IMM_I,11, 1, IB,           `IMM_I,13, 0, 1, 0, 0, 0, 1, 1, 32'd5,        9,  1, 32'd10,      13};
      vt[14] = '{1, IA,           `IMM_I,11, 1, IB,           `IMM_I,13, 0, 0, 1, 0, 0, 0, 0, 32'd5,        9,  0, 32'd10,      13};
      vt[15] = '{1, IA,           `IMM_I,14, 1, IB,           `IMM_I,15, 1, 1, 0, 0, 1, 0, 1, 32'd5,       14,  0, 32'd10,      13};
      vt[16] = '{0, 0,            `IMM_I, 0, 1, IU,           `IMM_U, 1, 1, 0, 0, 0, 0, 1, 0, 32'd5,       14,  1, 32'h12345000, 1};
      vt[17] = '{1, IA,           `IMM_I, 2, 0, 0,            `IMM_I, 0, 1, 0, 0, 0, 1, 0, 1, 32'd5,        2,  1, 32'h12345000, 1};
      vt[18] = '{1, IA,           `IMM_I, 3, 1, IB,           `IMM_I, 4, 1, 1, 0, 1, 0, 0, 0, 32'h0,        0,  0, 32'h0,        0};
      vt[19] = '{1, IA,           `IMM_I, 3, 1, IB,           `IMM_I, 4, 1, 1, 0, 0, 1, 0, 1, 32'd5,        3,  0, 32'h0,        0};

      for (int i = 0; i < 20; i++) cycle(vt[i], 1'b1);

`ifdef VSCALE_IMM_ARB_STATS_EN
      // Five contended cycles after reset, rsp1 stalled from the second one.
      rv = vt[18];
      cycle(rv, 1'b0);
      rv.rs = 0;
      for (int i = 0; i < 5; i++) begin
         rv.r1 = (i == 0);
         cycle(rv, 1'b0);
      end
      chk("stat_conflicts_5", {16'd0, stat_conflicts}, 32'd5);
`endif

      rv = vt[0];
      for (int i = 0; i < 3000; i++) begin
         rv.v0 = ($urandom_range(0, 9) < 7);
         rv.i0 = $urandom;
         rv.t0 = 2'($urandom_range(0, 3));
         rv.g0 = 4'($urandom_range(0, 15));
         rv.v1 = ($urandom_range(0, 9) < 7);
         rv.i1 = $urandom;
         rv.t1 = 2'($urandom_range(0, 3));
         rv.g1 = 4'($urandom_range(0, 15));
         rv.r0 = ($urandom_range(0, 9) < 6);
         rv.r1 = ($urandom_range(0, 9) < 6);
         rv.k  = ($urandom_range(0, 19) == 0);
         rv.rs = ($urandom_range(0, 99) == 0);
         cycle(rv, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
